// File: rtl/vga_stream_cipher.sv
// LFSR stream cipher on the VGA pixel path: XORs valid pixels with a per-frame keystream.
// Optional build macro VGA_SCR_FRAME_SALT_EN salts each frame's seed with an 8-bit frame counter.
module vga_stream_cipher #(
    parameter int              PIX_W  = 12,
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [LFSR_W-1:0] key_in,
    input  logic              frame_start,
    input  logic [1:0]        mode,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              pix_valid_out,
    output logic [PIX_W-1:0]  pix_out,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] shadow_key;
    // Set on the first reseed; keeps the old stream alive while a new key waits in ARMED.
    logic              stream_live;

    logic [LFSR_W-1:0] load_key;
    logic [LFSR_W-1:0] base_key;
    logic [LFSR_W-1:0] seed_val;
    logic [LFSR_W-1:0] cur_stream;
    logic [LFSR_W-1:0] lfsr_next;
    logic [PIX_W-1:0]  keystream;
    logic [PIX_W-1:0]  pix_data;
    logic              reseed;
    logic              running;
    logic              advance;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & TAPS), s[LFSR_W-1:1]};
    endfunction

    assign load_key = (key_in == '0) ? SEED : key_in;
    assign reseed   = frame_start && ((state != ST_IDLE) || key_load);
    // A key loaded in the same cycle as frame_start seeds this very frame.
    assign base_key = key_load ? load_key : shadow_key;

`ifdef VGA_SCR_FRAME_SALT_EN
    logic [7:0]        frame_cnt;
    logic [7:0]        salt;
    logic [LFSR_W-1:0] salted;

    assign salt     = key_load ? 8'd0 : frame_cnt;
    assign salted   = base_key ^ {{(LFSR_W-8){1'b0}}, salt};
    assign seed_val = (salted == '0) ? SEED : salted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (key_load) begin
            frame_cnt <= reseed ? 8'd1 : 8'd0;
        end else if (reseed) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign seed_val = base_key;
`endif

    assign cur_stream = reseed ? seed_val : lfsr;
    assign running    = reseed || stream_live;
    assign keystream  = cur_stream[PIX_W-1:0];
    assign advance    = pix_valid && running && (mode != 2'b10);
    assign lfsr_next  = advance ? lfsr_step(cur_stream) : cur_stream;

    always_comb begin
        pix_data = '0;
        case (mode)
            2'b00:   pix_data = pix_in;
            2'b11:   pix_data = '0;
            default: pix_data = running ? (pix_in ^ keystream) : '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            lfsr          <= SEED;
            shadow_key    <= SEED;
            stream_live   <= 1'b0;
            pix_out       <= '0;
            pix_valid_out <= 1'b0;
        end else begin
            pix_valid_out <= pix_valid;
            if (pix_valid) begin
                pix_out <= pix_data;
            end
            if (key_load) begin
                shadow_key <= load_key;
            end
            if (reseed) begin
                stream_live <= 1'b1;
            end
            lfsr <= lfsr_next;
            case (state)
                ST_IDLE: begin
                    if (key_load) begin
                        state <= reseed ? ST_RUN : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (frame_start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (key_load && !frame_start) begin
                        state <= ST_ARMED;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_vga_stream_cipher.sv
// Directed bench for vga_stream_cipher: expected pixels are queued when driven and
// compared one cycle later when the registered output appears.
module tb_vga_stream_cipher;

    localparam int PIX_W  = 12;
    localparam int LFSR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_load;
    logic [LFSR_W-1:0] key_in;
    logic              frame_start;
    logic [1:0]        mode;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_in;
    logic              pix_valid_out;
    logic [PIX_W-1:0]  pix_out;
    logic [1:0]        state_o;

    always #5 clk = ~clk;

    vga_stream_cipher dut (
        .clk           (clk),
        .reset         (reset),
        .key_load      (key_load),
        .key_in        (key_in),
        .frame_start   (frame_start),
        .mode          (mode),
        .pix_valid     (pix_valid),
        .pix_in        (pix_in),
        .pix_valid_out (pix_valid_out),
        .pix_out       (pix_out),
        .state_o       (state_o)
    );

    int checks = 0;
    int errors = 0;

    logic [PIX_W:0]    exp_q[$];
    logic [PIX_W-1:0]  exp_last;
    logic [LFSR_W-1:0] m_lfsr;
    logic              m_active;
    logic [PIX_W-1:0]  orig[8];
    logic [PIX_W-1:0]  c1[8];
    logic [PIX_W-1:0]  e_tmp;

    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic fb;
        fb = ^(s & 16'hB400);
        return {fb, s[15:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [11:0] p, input logic [1:0] m,
                        input logic fs, input logic kl, input logic [15:0] k, input logic [11:0] e);
        logic [12:0] exp_v;
        pix_valid   = v;
        pix_in      = p;
        mode        = m;
        frame_start = fs;
        key_load    = kl;
        key_in      = k;
        if (v) exp_last = e;
        exp_q.push_back({v, exp_last});
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        key_load    = 1'b0;
        pix_valid   = 1'b0;
        exp_v = exp_q.pop_front();
        check(tag, {19'b0, pix_valid_out, pix_out}, {19'b0, exp_v});
    endtask

    // Reference keystream model: compute expectation, then advance.
    task automatic px(input string tag, input logic fs, input logic [15:0] seed,
                      input logic [11:0] p, input logic [1:0] m, output logic [11:0] e_out);
        logic [11:0] e;
        if (fs) begin
            m_lfsr   = seed;
            m_active = 1'b1;
        end
        if (m == 2'b00)      e = p;
        else if (m == 2'b11) e = 12'h000;
        else if (m_active)   e = p ^ m_lfsr[11:0];
        else                 e = 12'h000;
        if (m_active && m != 2'b10) m_lfsr = model_next(m_lfsr);
        e_out = e;
        step(tag, 1'b1, p, m, fs, 1'b0, 16'h0, e);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step("gap", 1'b0, 12'h5A5, 2'b01, 1'b0, 1'b0, 16'h0, 12'h000);
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        check(tag, {30'b0, state_o}, {30'b0, exp});
    endtask

    initial begin
        reset = 1'b1; key_load = 1'b0; key_in = '0; frame_start = 1'b0;
        mode = 2'b00; pix_valid = 1'b0; pix_in = '0;
        exp_last = '0; m_active = 1'b0; m_lfsr = '0;
        orig[0] = 12'hFFF;
        orig[1] = 12'h000;
        for (int i = 2; i < 8; i++) orig[i] = 12'($urandom_range(0, 4095));

        repeat (3) @(posedge clk);
        #1;
        check("reset_pix_out", {20'b0, pix_out}, 32'h0);
        check("reset_valid_out", {31'b0, pix_valid_out}, 32'h0);
        check_state("reset_state", 2'b00);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        step("idle_blank", 1'b1, 12'hABC, 2'b01, 1'b0, 1'b0, 16'h0, 12'h000);
        check_state("idle_state", 2'b00);
        step("idle_bypass", 1'b1, 12'hABC, 2'b00, 1'b0, 1'b0, 16'h0, 12'hABC);

        step("key_load", 1'b0, 12'h000, 2'b01, 1'b0, 1'b1, 16'hACE1, 12'h000);
        check_state("armed_state", 2'b01);
        step("f1_first", 1'b1, orig[0], 2'b01, 1'b1, 1'b0, 16'h0, 12'h31E);
        check_state("run_state", 2'b10);
        m_lfsr = 16'hD670;
        m_active = 1'b1;
        step("f1_second", 1'b1, orig[1], 2'b01, 1'b0, 1'b0, 16'h0, 12'h670);
        m_lfsr = model_next(16'hD670);
        c1[0] = 12'h31E;
        c1[1] = 12'h670;
        for (int i = 2; i < 8; i++) px("f1_px", 1'b0, 16'h0, orig[i], 2'b01, c1[i]);

        // Same frame with idle gaps between pixels must yield the same ciphertext.
        step("reload2", 1'b0, 12'h000, 2'b01, 1'b0, 1'b1, 16'hACE1, 12'h000);
        for (int i = 0; i < 8; i++) begin
            step("f2_gapped", 1'b1, orig[i], 2'b01, (i == 0), 1'b0, 16'h0, c1[i]);
            gap(5);
        end

        step("reload3", 1'b0, 12'h000, 2'b01, 1'b0, 1'b1, 16'hACE1, 12'h000);
        for (int i = 0; i < 8; i++)
            step("f3_roundtrip", 1'b1, c1[i], 2'b01, (i == 0), 1'b0, 16'h0, orig[i]);

        step("reload4", 1'b0, 12'h000, 2'b01, 1'b0, 1'b1, 16'hACE1, 12'h000);
        px("f4_first", 1'b1, 16'hACE1, 12'h123, 2'b01, e_tmp);
        px("f4_px", 1'b0, 16'h0, 12'h456, 2'b01, e_tmp);
        step("f4_midload", 1'b0, 12'h000, 2'b01, 1'b0, 1'b1, 16'h1234, 12'h000);
        check_state("midload_state", 2'b01);
        px("f4_old_stream", 1'b0, 16'h0, 12'h789, 2'b01, e_tmp);
        px("f4_mode11", 1'b0, 16'h0, 12'hFED, 2'b11, e_tmp);
        px("f4_mode00", 1'b0, 16'h0, 12'h321, 2'b00, e_tmp);
        px("f4_after_modes", 1'b0, 16'h0, 12'h0F0, 2'b01, e_tmp);

        step("f5_newkey", 1'b1, 12'h000, 2'b01, 1'b1, 1'b0, 16'h0, 12'h234);
        check_state("f5_state", 2'b10);
`ifdef VGA_SCR_FRAME_SALT_EN
        step("f6_salt", 1'b1, 12'h000, 2'b01, 1'b1, 1'b0, 16'h0, 12'h235);
`else
        step("f6_nosalt", 1'b1, 12'h000, 2'b01, 1'b1, 1'b0, 16'h0, 12'h234);
`endif

        step("load_and_start", 1'b1, 12'h000, 2'b01, 1'b1, 1'b1, 16'h5555, 12'h555);
        check_state("load_start_state", 2'b10);
        m_lfsr = model_next(16'h5555);
        m_active = 1'b1;
        px("after_load_start", 1'b0, 16'h0, 12'h0F0, 2'b01, e_tmp);

        step("zero_key_load", 1'b0, 12'h000, 2'b01, 1'b0, 1'b1, 16'h0000, 12'h000);
        step("zero_key_frame", 1'b1, 12'h000, 2'b10, 1'b1, 1'b0, 16'h0, 12'h001);
        step("freeze1", 1'b1, 12'h000, 2'b10, 1'b0, 1'b0, 16'h0, 12'h001);
        step("freeze2", 1'b1, 12'h5A5, 2'b10, 1'b0, 1'b0, 16'h0, 12'h5A4);
        step("freeze3", 1'b1, 12'hFFF, 2'b10, 1'b0, 1'b0, 16'h0, 12'hFFE);
        step("unfreeze", 1'b1, 12'h000, 2'b01, 1'b0, 1'b0, 16'h0, 12'h001);
        step("advanced", 1'b1, 12'h000, 2'b01, 1'b0, 1'b0, 16'h0, 12'h000);

        step("pre_reset", 1'b1, 12'h123, 2'b00, 1'b0, 1'b0, 16'h0, 12'h123);
        pix_valid = 1'b1;
        pix_in    = 12'h456;
        mode      = 2'b01;
        #2 reset  = 1'b1;
        #1;
        check("midreset_pix_out", {20'b0, pix_out}, 32'h0);
        check("midreset_valid_out", {31'b0, pix_valid_out}, 32'h0);
        check_state("midreset_state", 2'b00);
        @(negedge clk);
        reset     = 1'b0;
        pix_valid = 1'b0;
        exp_last  = '0;
        m_active  = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_out", {19'b0, pix_valid_out, pix_out}, 32'h0);

        step("idle_frame_start", 1'b1, 12'hABC, 2'b01, 1'b1, 1'b0, 16'h0, 12'h000);
        check_state("idle_fs_state", 2'b00);
        step("idle_load_and_start", 1'b1, 12'h000, 2'b01, 1'b1, 1'b1, 16'h0BEE, 12'hBEE);
        check_state("idle_load_start_state", 2'b10);

        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
